counter_b4_core: RTL
====================

# counter_b4_core

Behavioural 4-bit, four-mode up/down/load counter: the device under test that the counter tester stimulates and checks. It consumes enable/mode/D from the tester each clock and returns count, ripple-carry-out and load indication. The synthesized netlist of this block provides the `_syn` outputs that are compared against this RTL cycle by cycle.

## Interface
- NBITS, 4, counter width; all arithmetic is modulo 2^NBITS.
- b4_clk  in  1  single clock; all state updates on rising edge.
- b4_reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- b4_enable  in  1  1 = perform the mode operation this edge; 0 = hold.
- b4_mode  in  2  operation select: 00 up-by-3, 01 down-by-1, 10 up-by-1, 11 parallel load.
- b4_D  in  NBITS  parallel load value, used only in mode 11.
- b4_Q  out  NBITS  registered count.
- b4_rco  out  1  registered ripple-carry-out: one-cycle pulse on wrap.
- b4_load  out  1  registered pulse: D was loaded this edge.

## Operation
- Reset (b4_reset=0): b4_Q=0, b4_rco=0, b4_load=0, asynchronously; held while low.
- b4_enable=0: b4_Q holds; b4_rco=0, b4_load=0.
- b4_enable=1, per mode (Q = current count, MAX = 2^NBITS-1):
  - 00: Q <= (Q+3) mod 2^NBITS; rco=1 iff Q >= MAX-2 (13,14,15 for NBITS=4); load=0.
  - 01: Q <= (Q-1) mod 2^NBITS; rco=1 iff Q==0 (wraps to MAX); load=0.
  - 10: Q <= (Q+1) mod 2^NBITS; rco=1 iff Q==MAX (wraps to 0); load=0.
  - 11: Q <= D; load=1; rco=0, even if D==MAX or D==0.
- Next-value arithmetic done at NBITS+1 bits; bit NBITS of the up sums is the wrap flag for modes 00/10; for mode 01 the wrap flag is the borrow (Q==0).
- b4_D ignored in modes 00/01/10; X on D outside mode 11 must not propagate to any output.
- No internal state beyond b4_Q, b4_rco, b4_load registers.

## Timing
- Latency: inputs sampled on rising edge N; b4_Q/b4_rco/b4_load valid after edge N, stable until edge N+1.
- rco and load are single-cycle pulses aligned with the new Q value; back-to-back wraps (e.g. mode 01 holding at 0 is impossible, but mode 00 from 13 then 0 re-wrap after 6 steps) produce separate pulses only when the condition recurs.
- Consecutive mode-11 cycles keep b4_load high continuously.
- Mode or enable change takes effect on the next rising edge only; no combinational path input-to-output.
- Reset asserted mid-count: outputs go to 0 without waiting for a clock; on reset release the first edge with enable=1 operates from Q=0 (mode 01 then yields Q=MAX, rco=1).
- Reset release is assumed synchronous to b4_clk by the driver; no internal synchronizer.

## Structure
- Shared include file counter_b4_defs.vh (guarded): mode constants MODE_UP3=2'b00, MODE_DN1=2'b01, MODE_UP1=2'b10, MODE_LOAD=2'b11, and STEP3=3; used by this block, the tester and the checker.
- One combinational sub-module counter_b4_step: inputs Q, mode, D; outputs next_q and wrap. Top-level holds only the three registers, enable gating and reset.
- Top-level must be synthesizable by the existing Yosys/Qflow flow; no delays, no initial blocks.

## Test plan
- Reset: hold b4_reset=0 for 6 cycles with enable=1, mode=10 -> b4_Q=0, rco=0, load=0 throughout; drop reset mid-count at Q=7 -> outputs 0 before the next edge.
- Up-by-1 wrap: load D=4'hE, then mode 10 for 3 cycles -> Q=F, 0 (rco=1 this cycle only), 1.
- Up-by-3 wrap: load D=4'hC, mode 00 -> Q=F (rco=0), then 2 (rco=1), then 5 (rco=0).
- Down-by-1 wrap: load D=4'h1, mode 01 -> Q=0 (rco=0), F (rco=1), E (rco=0).
- Load sequence 1,2,A,B,E,F in mode 11 on consecutive cycles -> Q follows D one edge later, b4_load stays 1, rco stays 0; then enable=0 -> Q holds F, load=0.
- Equivalence: 60 randomized enable/mode/D cycles against the synthesized netlist -> b4_Q, b4_rco, b4_load identical every posedge, log reports PASS only.

Source files
------------

// File: rtl/counter_b4_core_pkg.sv
// counter_b4_core_pkg: shared width, mode encodings and step constant for the 4-bit counter
package counter_b4_core_pkg;
   localparam int NBITS = 4;
   localparam int STEP3 = 3;
   typedef enum logic [1:0] {
      MODE_UP3  = 2'b00,
      MODE_DN1  = 2'b01,
      MODE_UP1  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;
endpackage

// File: rtl/counter_b4_core_step.sv
// counter_b4_core_step: combinational next-count and wrap computation for one mode step
module counter_b4_core_step
   import counter_b4_core_pkg::*;
(
   input  logic [NBITS-1:0] q,
   input  logic [1:0]       mode,
   input  logic [NBITS-1:0] d,
   output logic [NBITS-1:0] next_q,
   output logic             wrap
);
   logic [NBITS:0] up3;
   logic [NBITS:0] up1;
   // D only reaches next_q through the load arm, so X on D cannot leak in other modes
   always_comb begin
      up3    = {1'b0, q} + (NBITS+1)'(STEP3);
      up1    = {1'b0, q} + (NBITS+1)'(1);
      next_q = mode == MODE_LOAD ? d :
               mode == MODE_UP3  ? up3[NBITS-1:0] :
               mode == MODE_UP1  ? up1[NBITS-1:0] : q - NBITS'(1);
      wrap   = mode == MODE_UP3 ? up3[NBITS] :
               mode == MODE_UP1 ? up1[NBITS] :
               mode == MODE_DN1 ? (q == '0) : 1'b0;
   end
endmodule

// File: rtl/counter_b4_core.sv
// counter_b4_core: 4-bit up3/down1/up1/load counter with registered rco and load pulses
module counter_b4_core
   import counter_b4_core_pkg::*;
(
   input  logic             b4_clk,
   input  logic             b4_reset,
   input  logic             b4_enable,
   input  logic [1:0]       b4_mode,
   input  logic [NBITS-1:0] b4_D,
   output logic [NBITS-1:0] b4_Q,
   output logic             b4_rco,
   output logic             b4_load
);
   logic [NBITS-1:0] next_q;
   logic             wrap;
   counter_b4_core_step u_step (
      .q      (b4_Q),
      .mode   (b4_mode),
      .d      (b4_D),
      .next_q (next_q),
      .wrap   (wrap)
   );
   always_ff @(posedge b4_clk or negedge b4_reset) begin
      if (!b4_reset) begin
         b4_Q    <= '0;
         b4_rco  <= 1'b0;
         b4_load <= 1'b0;
      end else begin
         b4_Q    <= b4_enable ? next_q : b4_Q;
         b4_rco  <= b4_enable & wrap;
         b4_load <= b4_enable & (b4_mode == MODE_LOAD);
      end
   end
endmodule
